// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding, instruction field positions and defaults for alu_sequencer
package alu_seq_pkg;
    typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, LATCH, WB} state_e;
    localparam logic KIND_ALU = 1'b0;
    localparam logic KIND_LDI = 1'b1;
    localparam int KIND_BIT = 15;
    localparam int OP_MSB = 14;
    localparam int OP_LSB = 12;
    localparam int DST_MSB = 11;
    localparam int DST_LSB = 10;
    localparam int SRC0_MSB = 9;
    localparam int SRC0_LSB = 8;
    localparam int SRC1_MSB = 7;
    localparam int SRC1_LSB = 6;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;
    localparam int DATA_W_DEF = 16;
endpackage

// File: rtl/mc_regfile.sv
// mc_regfile: 4-entry register file, one sync write port, three comb read ports, async active-low clear
// Ports: clk, rst (async active-low), we/waddr/wdata (write), raddr0..2 -> rdata0..2 (combinational reads)
module mc_regfile #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [1:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [1:0]        raddr0,
    input  logic [1:0]        raddr1,
    input  logic [1:0]        raddr2,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] regs_q [4];
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) regs_q[i] <= '0;
        end else if (we) begin
            regs_q[waddr] <= wdata;
        end
    end
    assign rdata0 = regs_q[raddr0];
    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: drives the ALU datapath strobes/bus for one instruction at a time and owns the register file
// Ports: clk, rst (async active-low); instr/instr_valid/instr_ready handshake; done pulse;
//        bus_out/bus_in datapath bus; alu_in0/alu_in1/alu_out_latch/alu_out_en strobes; op_control opcode;
//        rd_sel/rd_data combinational debug read
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic              done,
    output logic [DATA_W-1:0] bus_out,
    input  logic [DATA_W-1:0] bus_in,
    output logic              alu_in0,
    output logic              alu_in1,
    output logic              alu_out_latch,
    output logic              alu_out_en,
    output logic [2:0]        op_control,
    input  logic [1:0]        rd_sel,
    output logic [DATA_W-1:0] rd_data
);
    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [1:0]        dst_q, dst_d, src0_q, src0_d, src1_q, src1_d;
    logic              done_q, done_d;
    logic [3:0]        strobe_q, strobe_d;
    logic              acc_alu, acc_ldi, we;
    logic [1:0]        waddr;
    logic [DATA_W-1:0] wdata, r_src0, r_src1;

    assign instr_ready = state_q == IDLE;

    always_comb begin
        acc_alu  = instr_valid && instr_ready && instr[KIND_BIT] == KIND_ALU;
        acc_ldi  = instr_valid && instr_ready && instr[KIND_BIT] == KIND_LDI;
        state_d  = acc_alu ? LOAD_A :
                   state_q == LOAD_A ? LOAD_B :
                   state_q == LOAD_B ? LATCH :
                   state_q == LATCH ? WB : IDLE;
        op_d     = acc_alu ? instr[OP_MSB:OP_LSB] : op_q;
        dst_d    = acc_alu ? instr[DST_MSB:DST_LSB] : dst_q;
        src0_d   = acc_alu ? instr[SRC0_MSB:SRC0_LSB] : src0_q;
        src1_d   = acc_alu ? instr[SRC1_MSB:SRC1_LSB] : src1_q;
        // LDI writes at its accept edge; ALU results are written at the WB edge
        we       = acc_ldi || state_q == WB;
        waddr    = acc_ldi ? instr[DST_MSB:DST_LSB] : dst_q;
        wdata    = acc_ldi ? DATA_W'(instr[IMM_MSB:IMM_LSB]) : bus_in;
        done_d   = we;
        // strobes are decoded from the next state so they are flops, cleared directly by reset
        strobe_d = {state_d == LOAD_A, state_d == LOAD_B, state_d == LATCH, state_d == WB};
        bus_out  = state_q == LOAD_A ? r_src0 : state_q == LOAD_B ? r_src1 : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            dst_q    <= '0;
            src0_q   <= '0;
            src1_q   <= '0;
            done_q   <= 1'b0;
            strobe_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            src0_q   <= src0_d;
            src1_q   <= src1_d;
            done_q   <= done_d;
            strobe_q <= strobe_d;
        end
    end

    assign {alu_in0, alu_in1, alu_out_latch, alu_out_en} = strobe_q;
    assign op_control = op_q;
    assign done       = done_q;

    mc_regfile #(.DATA_W(DATA_W)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr0(src0_q),
        .raddr1(src1_q),
        .raddr2(rd_sel),
        .rdata0(r_src0),
        .rdata1(r_src1),
        .rdata2(rd_data)
    );
endmodule
